trem_ctrl: RTL and testbench
============================

TREM_CTRL -- requirements
Module: trem_ctrl

Interface
REQ-001 Parameter DIV_BASE, 48000, clk_48 cycles per LFO step at slowest rate (min 16, divisible by 8).
REQ-002 Parameter GAIN_MIN, 64, LFO trough gain (unsigned 8-bit, < GAIN_MAX).
REQ-003 Parameter GAIN_MAX, 255, LFO peak gain; 255 = unity pass-through.
REQ-004 clk_48  in  1  single system clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 en  in  1  tremolo effect enable (level).
REQ-007 options  in  4  one-hot rate request: 0001 slowest ... 1000 fastest.
REQ-008 sample_stb  in  1  one-cycle pulse per new audio sample x.
REQ-009 gain  out  8  gain word for the tremolo multiplier, held between strobes.
REQ-010 gain_vld  out  1  one-cycle pulse: gain updated for current sample.
REQ-011 rate_sel  out  4  one-hot rate currently applied.
REQ-012 active  out  1  high in any state other than IDLE.

Function
REQ-013 Step period SHALL be DIV_BASE >> k for rate_sel bit k set (k=0..3): 0001 -> DIV_BASE, 1000 -> DIV_BASE/8.
REQ-014 Divider counts 0..period-1, emits step tick when count == period-1 and wraps to 0; counter runs only while active.
REQ-015 FSM states IDLE, DOWN, UP, PARK; internal lfo register 8-bit unsigned.
REQ-016 IDLE: lfo = GAIN_MAX; en=1 -> DOWN next cycle, divider cleared.
REQ-017 DOWN: on tick lfo -= 1; tick when lfo == GAIN_MIN+1 -> lfo = GAIN_MIN and go UP.
REQ-018 UP: on tick lfo += 1; tick when lfo == GAIN_MAX-1 -> lfo = GAIN_MAX and go DOWN.
REQ-019 lfo SHALL never leave [GAIN_MIN, GAIN_MAX]; no wrap-around.
REQ-020 en=0 in DOWN or UP -> PARK next cycle (see REQ-031).
REQ-021 PARK: on tick lfo += 1 toward GAIN_MAX; reaching GAIN_MAX -> IDLE; en=1 in PARK -> UP, lfo unchanged.
REQ-022 options sampled every cycle; applied to rate_sel only in IDLE or on the cycle lfo reaches GAIN_MAX; divider cleared on application.
REQ-023 options not one-hot (0000 or >1 bit set) SHALL be ignored; rate_sel keeps previous value.
REQ-024 On sample_stb, gain <= lfo next edge and gain_vld pulses that same cycle (latency 1); gain otherwise holds.
REQ-025 Tick and sample_stb in same cycle: gain captures pre-tick lfo.
REQ-026 sample_stb in IDLE still updates gain (= GAIN_MAX) and pulses gain_vld.

Reset
REQ-027 rst_n=0 SHALL immediately force: state IDLE, lfo = GAIN_MAX, gain = GAIN_MAX, gain_vld = 0, rate_sel = 0001, active = 0, divider = 0.
REQ-028 Reset mid-ramp aborts with no residual step; first tick after release comes a full period after DOWN entry.
REQ-029 Deassertion is applied to a synchronised release; no output changes on the release edge.

Configuration
REQ-030 Macro TREM_CTRL_SOFTSTOP_EN selects stop behaviour.
REQ-031 Defined: en=0 enters PARK and ramps to GAIN_MAX per REQ-021.
REQ-032 Undefined: PARK not built; en=0 in DOWN/UP -> IDLE next cycle, lfo snaps to GAIN_MAX.

Verification (DIV_BASE=16, GAIN_MIN=250, GAIN_MAX=255)
REQ-033 Reset, en=1, options=0001, strobe every cycle -> gain 255,254,... one step per 16 cycles, 250 at step 5, then rising.
REQ-034 options 0001 -> 1000 mid DOWN -> rate_sel stays 0001 until lfo=255, then 1000, steps every 2 cycles.
REQ-035 options=0110 in IDLE -> rate_sel remains 0001, no error.
REQ-036 en 1->0 at lfo=252: macro defined -> 253,254,255 then IDLE, active=0; undefined -> lfo=255, IDLE next cycle.
REQ-037 rst_n low at lfo=251 during tick -> gain=255, gain_vld=0, rate_sel=0001 asynchronously.
REQ-038 sample_stb coincident with tick at lfo=253 in DOWN -> gain=253 with gain_vld, next strobe gain=252.

Source files
------------

// File: rtl/trem_ctrl.sv
// ---------------------------------------------------------------------------
// trem_ctrl -- tremolo LFO / gain controller
//
// Generates a triangle-wave gain word that sweeps between GAIN_MIN and
// GAIN_MAX, one unit per LFO step. The step period comes from a divider whose
// length is selected by a one-hot rate request. The current LFO value is
// latched into the gain output on every audio sample strobe.
//
// Parameters
//   DIV_BASE  clock cycles per LFO step at the slowest rate (>=16, /8 exact)
//   GAIN_MIN  trough gain (unsigned 8-bit, below GAIN_MAX)
//   GAIN_MAX  peak gain (255 = unity)
//
// Ports
//   clk_48      in   1  system clock, rising edge
//   rst_n       in   1  asynchronous active-low reset (release is synchronised)
//   en          in   1  tremolo enable (level)
//   options     in   4  one-hot rate request, 0001 slowest .. 1000 fastest
//   sample_stb  in   1  one-cycle pulse per new audio sample
//   gain        out  8  gain word, held between strobes
//   gain_vld    out  1  one-cycle pulse when gain was refreshed
//   rate_sel    out  4  one-hot rate currently applied
//   active      out  1  high whenever the controller is not idle
//
// Build option
//   TREM_CTRL_SOFTSTOP_EN  defined: dropping en ramps the LFO back up to
//                          GAIN_MAX (PARK) before going idle.
//                          undefined: dropping en snaps to GAIN_MAX and idles.
// ---------------------------------------------------------------------------
module trem_ctrl #(
  parameter int DIV_BASE = 48000,
  parameter int GAIN_MIN = 64,
  parameter int GAIN_MAX = 255
) (
  input  logic       clk_48,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] options,
  input  logic       sample_stb,
  output logic [7:0] gain,
  output logic       gain_vld,
  output logic [3:0] rate_sel,
  output logic       active
);

  localparam int CNT_W = $clog2(DIV_BASE);

  localparam logic [7:0] G_MIN    = 8'(GAIN_MIN);
  localparam logic [7:0] G_MAX    = 8'(GAIN_MAX);
  localparam logic [7:0] G_MIN_P1 = 8'(GAIN_MIN + 1);
  localparam logic [7:0] G_MAX_M1 = 8'(GAIN_MAX - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DOWN = 2'd1;
  localparam logic [1:0] S_UP   = 2'd2;
`ifdef TREM_CTRL_SOFTSTOP_EN
  localparam logic [1:0] S_PARK = 2'd3;
`endif

  // Terminal count for the divider at a given one-hot rate.
  function automatic logic [CNT_W-1:0] period_m1(input logic [3:0] r);
    case (r)
      4'b0010: return CNT_W'((DIV_BASE >> 1) - 1);
      4'b0100: return CNT_W'((DIV_BASE >> 2) - 1);
      4'b1000: return CNT_W'((DIV_BASE >> 3) - 1);
      default: return CNT_W'(DIV_BASE - 1);
    endcase
  endfunction

  logic [1:0]       sync_q;
  logic             rst_int_n;
  logic [1:0]       state_q, state_d;
  logic [7:0]       lfo_q, lfo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       rate_q, rate_d;
  logic [7:0]       gain_q, gain_d;
  logic             vld_q, vld_d;
  logic             tick;
  logic             reach_max;
  logic             opt_onehot;
  logic             run;

  // Reset asserts immediately but releases two clock edges after rst_n
  // rises, so the first functional edge never coincides with the release.
  always_ff @(posedge clk_48 or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], 1'b1};
  end
  assign rst_int_n = sync_q[1];

  assign run        = (state_q != S_IDLE);
  assign tick       = run && (cnt_q == period_m1(rate_q));
  assign opt_onehot = (options != 4'b0000) && ((options & (options - 4'b0001)) == 4'b0000);

  always_comb begin
    state_d   = state_q;
    lfo_d     = lfo_q;
    rate_d    = rate_q;
    reach_max = 1'b0;
    cnt_d     = run ? (tick ? '0 : cnt_q + CNT_W'(1)) : '0;

    // The strobe always captures the LFO value from before any step this cycle.
    vld_d  = sample_stb;
    gain_d = sample_stb ? lfo_q : gain_q;

    case (state_q)
      S_IDLE: begin
        lfo_d = G_MAX;
        if (en) state_d = S_DOWN;
      end
      S_DOWN, S_UP: begin
        if (!en) begin
`ifdef TREM_CTRL_SOFTSTOP_EN
          state_d = S_PARK;
`else
          state_d = S_IDLE;
          lfo_d   = G_MAX;
`endif
        end else if (tick) begin
          if (state_q == S_DOWN) begin
            if (lfo_q <= G_MIN_P1) begin
              lfo_d   = G_MIN;
              state_d = S_UP;
            end else begin
              lfo_d = lfo_q - 8'd1;
            end
          end else begin
            // Compare with >= so a climb that starts at the peak cannot wrap.
            if (lfo_q >= G_MAX_M1) begin
              lfo_d     = G_MAX;
              state_d   = S_DOWN;
              reach_max = 1'b1;
            end else begin
              lfo_d = lfo_q + 8'd1;
            end
          end
        end
      end
`ifdef TREM_CTRL_SOFTSTOP_EN
      S_PARK: begin
        if (en) begin
          state_d = S_UP;
        end else if (lfo_q >= G_MAX) begin
          // Parked while already at the peak: nothing left to ramp.
          state_d = S_IDLE;
        end else if (tick) begin
          if (lfo_q >= G_MAX_M1) begin
            lfo_d     = G_MAX;
            state_d   = S_IDLE;
            reach_max = 1'b1;
          end else begin
            lfo_d = lfo_q + 8'd1;
          end
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        lfo_d   = G_MAX;
      end
    endcase

    // Rate changes only land at a waveform peak (or while idle) so the
    // triangle never changes slope mid-ramp; illegal requests are dropped.
    if (((state_q == S_IDLE) || reach_max) && opt_onehot) begin
      rate_d = options;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk_48 or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= S_IDLE;
      lfo_q   <= G_MAX;
      cnt_q   <= '0;
      rate_q  <= 4'b0001;
      gain_q  <= G_MAX;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lfo_q   <= lfo_d;
      cnt_q   <= cnt_d;
      rate_q  <= rate_d;
      gain_q  <= gain_d;
      vld_q   <= vld_d;
    end
  end

  assign gain     = gain_q;
  assign gain_vld = vld_q;
  assign rate_sel = rate_q;
  assign active   = run;

endmodule

// File: tb/tb_trem_ctrl.sv
module tb_trem_ctrl;

  localparam int DIV_BASE = 16;
  localparam int GMIN     = 250;
  localparam int GMAX     = 255;

  logic       clk_48 = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] options;
  logic       sample_stb;
  logic [7:0] gain;
  logic       gain_vld;
  logic [3:0] rate_sel;
  logic       active;

  int n_chk  = 0;
  int n_fail = 0;

  trem_ctrl #(.DIV_BASE(DIV_BASE), .GAIN_MIN(GMIN), .GAIN_MAX(GMAX)) dut (
    .clk_48     (clk_48),
    .rst_n      (rst_n),
    .en         (en),
    .options    (options),
    .sample_stb (sample_stb),
    .gain       (gain),
    .gain_vld   (gain_vld),
    .rate_sel   (rate_sel),
    .active     (active)
  );

  always #5 clk_48 = ~clk_48;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: LFO value, direction of travel (-1 falling, +1 rising,
  // 0 stopped), a parking flag, cycles elapsed in the current step, rate.
  int m_lfo, m_dir, m_cnt, m_rate, m_gain;
  bit m_park, m_vld;

  function automatic bit m_active();
    return (m_dir != 0) || m_park;
  endfunction

  task automatic model_reset();
    m_lfo = GMAX; m_gain = GMAX; m_vld = 0; m_rate = 1;
    m_dir = 0; m_park = 0; m_cnt = 0;
  endtask

  task automatic model_step(input bit e, input logic [3:0] opt, input bit stb);
    int per;
    bit act, tk, at_peak;
    per     = DIV_BASE >> $clog2(m_rate);
    act     = m_active();
    tk      = act && (m_cnt == per - 1);
    at_peak = 0;
    if (stb) begin m_gain = m_lfo; m_vld = 1; end
    else m_vld = 0;
    if (!act) begin
      m_cnt = 0; m_lfo = GMAX; at_peak = 1;
      if (e) m_dir = -1;
    end else begin
      m_cnt = tk ? 0 : m_cnt + 1;
      if (m_park) begin
        if (e) begin m_park = 0; m_dir = 1; end
        else if (m_lfo >= GMAX) m_park = 0;
        else if (tk) begin
          m_lfo = m_lfo + 1;
          if (m_lfo >= GMAX) begin m_lfo = GMAX; m_park = 0; at_peak = 1; end
        end
      end else if (!e) begin
`ifdef TREM_CTRL_SOFTSTOP_EN
        m_park = 1; m_dir = 0;
`else
        m_dir = 0; m_lfo = GMAX;
`endif
      end else if (tk) begin
        m_lfo = m_lfo + m_dir;
        if (m_lfo <= GMIN) begin m_lfo = GMIN; m_dir = 1; end
        else if (m_lfo >= GMAX) begin m_lfo = GMAX; m_dir = -1; at_peak = 1; end
      end
    end
    if (at_peak && $countones(opt) == 1) begin m_rate = int'(opt); m_cnt = 0; end
  endtask

  task automatic run_cycle(input bit e, input logic [3:0] opt, input bit stb);
    en = e; options = opt; sample_stb = stb;
    @(posedge clk_48);
    model_step(e, opt, stb);
    #1;
    check_eq("gain",     gain,     m_gain);
    check_eq("gain_vld", gain_vld, m_vld);
    check_eq("rate_sel", rate_sel, m_rate);
    check_eq("active",   active,   m_active());
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_gain",     gain,     GMAX);
    check_eq("rst_gain_vld", gain_vld, 0);
    check_eq("rst_rate_sel", rate_sel, 4'b0001);
    check_eq("rst_active",   active,   0);
    model_reset();
    en = 1'b0; options = 4'b0001; sample_stb = 1'b0;
    repeat (2) @(posedge clk_48);
    #2;
    rst_n = 1'b1;
    repeat (4) run_cycle(1'b0, 4'b0001, 1'b0);
  endtask

  initial begin
    int min_g;
    bit e;
    logic [3:0] opt;
    rst_n = 1'b1; en = 1'b0; options = 4'b0001; sample_stb = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk_48);
    #1;
    check_eq("init_gain",     gain,     GMAX);
    check_eq("init_gain_vld", gain_vld, 0);
    check_eq("init_rate_sel", rate_sel, 4'b0001);
    check_eq("init_active",   active,   0);
    model_reset();
    rst_n = 1'b1;
    repeat (4) run_cycle(1'b0, 4'b0001, 1'b0);

    // Illegal rate request while idle is ignored.
    repeat (3) run_cycle(1'b0, 4'b0110, 1'b0);
    check_eq("illegal_opt_idle", rate_sel, 4'b0001);
    run_cycle(1'b0, 4'b0000, 1'b1);
    check_eq("zero_opt_idle", rate_sel, 4'b0001);
    check_eq("idle_strobe_gain", gain, GMAX);

    // Slow sweep with a strobe every cycle; faster rate requested mid-fall.
    min_g = 999;
    for (int i = 0; i < 200; i++) begin
      run_cycle(1'b1, (i < 20) ? 4'b0001 : 4'b1000, 1'b1);
      if (int'(gain) < min_g) min_g = int'(gain);
      if (i == 100) check_eq("rate_held_mid_ramp", rate_sel, 4'b0001);
    end
    check_eq("sweep_trough", min_g, GMIN);
    check_eq("rate_after_peak", rate_sel, 4'b1000);

    // Stop and let the controller return to idle.
    for (int i = 0; i < 40; i++) run_cycle(1'b0, 4'b1000, 1'b0);
    check_eq("stopped_idle", active, 0);

    // Reset mid-ramp at the slow rate.
    for (int i = 0; i < 70; i++) run_cycle(1'b1, 4'b0001, 1'b1);
    do_reset();

    // Randomised stimulus.
    e = 1'b0; opt = 4'b0001;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) e = ~e;
      if ($urandom_range(0, 39) == 0)
        opt = ($urandom_range(0, 1) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
      run_cycle(e, opt, $urandom_range(0, 2) == 0);
      if ($urandom_range(0, 799) == 0) begin
        do_reset();
        e = 1'b0; opt = 4'b0001;
      end
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
